// File: rtl/aes_pkg.sv
// Shared AES definitions: field arithmetic helpers, mode codes and FSM states.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    localparam logic [1:0] MODE_FWD = 2'b00;
    localparam logic [1:0] MODE_INV = 2'b01;
    localparam logic [1:0] MODE_BYP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } eng_state_t;

    // Multiply by x in GF(2^8), reducing by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // General GF(2^8) multiply (shift-and-add).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc ^= p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational single-column MixColumns / InvMixColumns / bypass.
module mix_column_unit
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic [1:0]  mode,
    output logic [31:0] col_out
);

    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    logic [7:0] w_u, w_v;
    logic [7:0] w_b0, w_b1, w_b2, w_b3;
    logic [7:0] w_f0, w_f1, w_f2, w_f3;

    // Inverse = forward applied to a pre-conditioned column: b_r = a_r ^ 4*(a_r ^ a_{r+2}),
    // so one forward network (and its xtime logic) serves both directions.
    always_comb begin
        w_a0 = col_in[31:24];
        w_a1 = col_in[23:16];
        w_a2 = col_in[15:8];
        w_a3 = col_in[7:0];
        w_u  = xtime(xtime(w_a0 ^ w_a2));
        w_v  = xtime(xtime(w_a1 ^ w_a3));
        if (mode == MODE_INV) begin
            w_b0 = w_a0 ^ w_u;
            w_b1 = w_a1 ^ w_v;
            w_b2 = w_a2 ^ w_u;
            w_b3 = w_a3 ^ w_v;
        end else begin
            w_b0 = w_a0;
            w_b1 = w_a1;
            w_b2 = w_a2;
            w_b3 = w_a3;
        end
        w_f0 = xtime(w_b0 ^ w_b1) ^ w_b1 ^ w_b2 ^ w_b3;
        w_f1 = xtime(w_b1 ^ w_b2) ^ w_b2 ^ w_b3 ^ w_b0;
        w_f2 = xtime(w_b2 ^ w_b3) ^ w_b3 ^ w_b0 ^ w_b1;
        w_f3 = xtime(w_b3 ^ w_b0) ^ w_b0 ^ w_b1 ^ w_b2;
        if (mode == MODE_FWD || mode == MODE_INV) begin
            col_out = {w_f0, w_f1, w_f2, w_f3};
        end else begin
            col_out = col_in;
        end
    end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative 128-bit MixColumns engine, COLS_PER_CYCLE columns per clock, valid/ready on both sides.
module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_mode,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [1:0]   out_mode
);

    localparam int NGRP = 4 / COLS_PER_CYCLE;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    eng_state_t     r_state;
    logic [127:0]   r_work;
    logic [1:0]     r_mode;
    logic [GW-1:0]  r_grp;
    logic           r_out_valid;

    logic [31:0]    w_col_in  [COLS_PER_CYCLE];
    logic [31:0]    w_col_out [COLS_PER_CYCLE];
    logic [127:0]   w_work_next;
    logic           w_last;

    // Select the columns of the current group from the working register.
    always_comb begin
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
            w_col_in[j] = r_work[127 - 32 * ((32'(r_grp) * COLS_PER_CYCLE + j) & 3) -: 32];
        end
    end

    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_unit
        mix_column_unit u_mcu (
            .col_in  (w_col_in[j]),
            .mode    (r_mode),
            .col_out (w_col_out[j])
        );
    end

    // Merge the transformed group back into the working state.
    always_comb begin
        w_work_next = r_work;
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
            w_work_next[127 - 32 * ((32'(r_grp) * COLS_PER_CYCLE + j) & 3) -: 32] = w_col_out[j];
        end
        w_last = (r_grp == GW'(NGRP - 1));
    end

    // Transaction FSM: capture, iterate over column groups, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_mode      <= MODE_FWD;
            r_grp       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_work  <= in_state;
                        r_mode  <= in_mode;
                        r_grp   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_work <= w_work_next;
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_grp <= r_grp + GW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_work  <= in_state;
                            r_mode  <= in_mode;
                            r_grp   <= '0;
                            r_state <= ST_BUSY;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Handshake and result outputs; in_ready is the only combinational path from inputs.
    always_comb begin
        in_ready  = !rst && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
        out_valid = r_out_valid;
        out_state = r_work;
        out_mode  = r_mode;
    end

endmodule
